// File: rtl/sim_video_pkg.sv
// Shared types and helpers for the simulation video output path.
// Holds the raster-geometry FSM states and the colour bit-replication function.
package sim_video_pkg;

    localparam int DEF_IN_W  = 3;
    localparam int DEF_OUT_W = 8;
    localparam int MAX_W     = 16;
    localparam int IDX_W     = $clog2(MAX_W);

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } geom_state_t;

    // Output bit (out_w-1-i) takes input bit (in_w-1 - i mod in_w): MSB-first replication.
    function automatic logic [MAX_W-1:0] expand(input logic [MAX_W-1:0] c,
                                                input int in_w,
                                                input int out_w);
        logic [MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < out_w) begin
                res[IDX_W'(out_w - 1 - i)] = c[IDX_W'(in_w - 1 - (i % in_w))];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sim_raster_meter.sv
// Sync edge detection, pixel/line counters and raster-geometry lock FSM.
// Measurements update on the same clock as the ce strobe carrying the edge.
module sim_raster_meter
    import sim_video_pkg::*;
#(
    parameter int CNT_W = 10,
    parameter int FRM_W = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ce,
    input  logic             i_hs,
    input  logic             i_vs,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic [CNT_W-1:0] o_line_len,
    output logic [CNT_W-1:0] o_frame_lines,
    output logic [FRM_W-1:0] o_frame_cnt,
    output logic             o_frame_start,
    output logic             o_geom_valid
);

    logic             r_hs_d;
    logic             r_vs_d;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [CNT_W-1:0] r_line_len;
    logic [CNT_W-1:0] r_frame_lines;
    logic [FRM_W-1:0] r_frame_cnt;
    logic             r_frame_start;
    geom_state_t      r_state;
    logic [CNT_W-1:0] r_ref_line;
    logic [CNT_W-1:0] r_ref_lines;
    logic             r_geom_valid;

    logic             w_hs_edge;
    logic             w_vs_edge;
    logic [CNT_W-1:0] w_line_meas;
    logic [CNT_W-1:0] w_frame_meas;
    logic [CNT_W-1:0] w_line_now;
    logic             w_match;

    assign w_hs_edge    = i_ce & i_hs & ~r_hs_d;
    assign w_vs_edge    = i_ce & i_vs & ~r_vs_d;
    assign w_line_meas  = (r_h_cnt == '1) ? r_h_cnt : r_h_cnt + 1'b1;
    assign w_frame_meas = (r_v_cnt == '1) ? r_v_cnt : r_v_cnt + 1'b1;

    // The line length compared at a vs edge is the one being measured on this same strobe.
    assign w_line_now = w_hs_edge ? w_line_meas : r_line_len;
    assign w_match    = (w_line_now != '1) && (w_frame_meas != '1) &&
                        (w_line_now == r_ref_line) && (w_frame_meas == r_ref_lines);

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_d        <= 1'b0;
            r_vs_d        <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_vs_edge;
            if (i_ce) begin
                r_hs_d <= i_hs;
                r_vs_d <= i_vs;
            end
            if (w_hs_edge) begin
                r_line_len <= w_line_meas;
                r_h_cnt    <= '0;
            end else if (i_ce) begin
                r_h_cnt <= w_line_meas;
            end
            // A coincident vs edge wins: the line increment is dropped and v_cnt restarts.
            if (w_vs_edge) begin
                r_frame_lines <= w_frame_meas;
                r_v_cnt       <= '0;
                r_frame_cnt   <= r_frame_cnt + 1'b1;
            end else if (w_hs_edge) begin
                r_v_cnt <= w_frame_meas;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= UNLOCK;
            r_ref_line   <= '0;
            r_ref_lines  <= '0;
            r_geom_valid <= 1'b0;
        end else if (w_vs_edge) begin
            case (r_state)
                UNLOCK: begin
                    r_state     <= CHECK;
                    r_ref_line  <= w_line_now;
                    r_ref_lines <= w_frame_meas;
                end
                CHECK: begin
                    if (w_match) begin
                        r_state      <= LOCKED;
                        r_geom_valid <= 1'b1;
                    end else begin
                        r_ref_line  <= w_line_now;
                        r_ref_lines <= w_frame_meas;
                    end
                end
                LOCKED: begin
                    if (!w_match) begin
                        r_state      <= CHECK;
                        r_geom_valid <= 1'b0;
                        r_ref_line   <= w_line_now;
                        r_ref_lines  <= w_frame_meas;
                    end
                end
                default: begin
                    r_state      <= UNLOCK;
                    r_geom_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_line_len    = r_line_len;
    assign o_frame_lines = r_frame_lines;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_frame_start = r_frame_start;
    assign o_geom_valid  = r_geom_valid;

endmodule

// File: rtl/sim_video_out.sv
// Video output stage: two-stage colour/sync pipeline with bit-replicated expansion,
// blank gating and active-low VGA syncs, plus raster geometry measurement.
module sim_video_out
    import sim_video_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter bit BGR       = 1'b1,
    parameter bit HS_IN_LOW = 1'b0,
    parameter bit VS_IN_LOW = 1'b0,
    parameter int CNT_W     = 10,
    parameter int FRM_W     = 16
)(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [3*IN_W-1:0] rgb_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              hblank_i,
    input  logic              vblank_i,
    output logic [OUT_W-1:0]  VGA_R,
    output logic [OUT_W-1:0]  VGA_G,
    output logic [OUT_W-1:0]  VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_DE,
    output logic [CNT_W-1:0]  h_cnt_o,
    output logic [CNT_W-1:0]  v_cnt_o,
    output logic [CNT_W-1:0]  line_len_o,
    output logic [CNT_W-1:0]  frame_lines_o,
    output logic [FRM_W-1:0]  frame_cnt_o,
    output logic              frame_start_o,
    output logic              geom_valid_o
);

    generate
        if (IN_W < 1 || IN_W > OUT_W || OUT_W > MAX_W) begin : g_bad_width
            $error("sim_video_out: need 1 <= IN_W <= OUT_W <= %0d", MAX_W);
        end
    endgenerate

    logic              w_hs;
    logic              w_vs;
    logic [IN_W-1:0]   w_r;
    logic [IN_W-1:0]   w_g;
    logic [IN_W-1:0]   w_b;
    logic [OUT_W-1:0]  w_r_exp;
    logic [OUT_W-1:0]  w_g_exp;
    logic [OUT_W-1:0]  w_b_exp;

    logic [IN_W-1:0]   r_s1_r;
    logic [IN_W-1:0]   r_s1_g;
    logic [IN_W-1:0]   r_s1_b;
    logic              r_s1_hs;
    logic              r_s1_vs;
    logic              r_s1_blank;

    assign w_hs = hsync_i ^ HS_IN_LOW;
    assign w_vs = vsync_i ^ VS_IN_LOW;

    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    always_comb begin
        w_g = rgb_i[IN_W +: IN_W];
        if (BGR) begin
            w_r = rgb_i[0 +: IN_W];
            w_b = rgb_i[2*IN_W +: IN_W];
        end else begin
            w_r = rgb_i[2*IN_W +: IN_W];
            w_b = rgb_i[0 +: IN_W];
        end
    end

    assign w_r_exp = OUT_W'(expand(MAX_W'(r_s1_r), IN_W, OUT_W));
    assign w_g_exp = OUT_W'(expand(MAX_W'(r_s1_g), IN_W, OUT_W));
    assign w_b_exp = OUT_W'(expand(MAX_W'(r_s1_b), IN_W, OUT_W));

    // NOTE: stage 1 resets to "blanked, syncs inactive" so stale contents never leak a visible pixel.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_r     <= '0;
            r_s1_g     <= '0;
            r_s1_b     <= '0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s1_blank <= 1'b1;
        end else if (ce_pix) begin
            r_s1_r     <= w_r;
            r_s1_g     <= w_g;
            r_s1_b     <= w_b;
            r_s1_hs    <= w_hs;
            r_s1_vs    <= w_vs;
            r_s1_blank <= hblank_i | vblank_i;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
            VGA_DE <= 1'b0;
        end else if (ce_pix) begin
            VGA_R  <= r_s1_blank ? '0 : w_r_exp;
            VGA_G  <= r_s1_blank ? '0 : w_g_exp;
            VGA_B  <= r_s1_blank ? '0 : w_b_exp;
            VGA_HS <= ~r_s1_hs;
            VGA_VS <= ~r_s1_vs;
            VGA_DE <= ~r_s1_blank;
        end
    end

    sim_raster_meter #(
        .CNT_W (CNT_W),
        .FRM_W (FRM_W)
    ) u_meter (
        .clk           (clk_sys),
        .rst_n         (reset_n),
        .i_ce          (ce_pix),
        .i_hs          (w_hs),
        .i_vs          (w_vs),
        .o_h_cnt       (h_cnt_o),
        .o_v_cnt       (v_cnt_o),
        .o_line_len    (line_len_o),
        .o_frame_lines (frame_lines_o),
        .o_frame_cnt   (frame_cnt_o),
        .o_frame_start (frame_start_o),
        .o_geom_valid  (geom_valid_o)
    );

endmodule

// File: tb/tb_sim_video_out.sv
// Self-checking bench for sim_video_out (IN_W=3, OUT_W=8, BGR=1, CNT_W=10).
// Colour pipeline via table + scoreboard; raster meter via hand-written sequences.
module tb_sim_video_out;

    localparam int IN_W  = 3;
    localparam int OUT_W = 8;
    localparam int CNT_W = 10;
    localparam int FRM_W = 16;
    localparam int H_TOT = 96;
    localparam int V_TOT = 24;
    localparam int NVEC  = 12;

    logic              clk_sys  = 1'b0;
    logic              reset_n  = 1'b0;
    logic              ce_pix   = 1'b0;
    logic [3*IN_W-1:0] rgb_i    = '0;
    logic              hsync_i  = 1'b0;
    logic              vsync_i  = 1'b0;
    logic              hblank_i = 1'b0;
    logic              vblank_i = 1'b0;
    logic [OUT_W-1:0]  VGA_R, VGA_G, VGA_B;
    logic              VGA_HS, VGA_VS, VGA_DE;
    logic [CNT_W-1:0]  h_cnt_o, v_cnt_o, line_len_o, frame_lines_o;
    logic [FRM_W-1:0]  frame_cnt_o;
    logic              frame_start_o, geom_valid_o;

    int n_checks = 0;
    int n_errors = 0;

    sim_video_out #(
        .IN_W(IN_W), .OUT_W(OUT_W), .BGR(1'b1), .HS_IN_LOW(1'b0), .VS_IN_LOW(1'b0),
        .CNT_W(CNT_W), .FRM_W(FRM_W)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .rgb_i(rgb_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .hblank_i(hblank_i), .vblank_i(vblank_i),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
        .h_cnt_o(h_cnt_o), .v_cnt_o(v_cnt_o), .line_len_o(line_len_o),
        .frame_lines_o(frame_lines_o), .frame_cnt_o(frame_cnt_o),
        .frame_start_o(frame_start_o), .geom_valid_o(geom_valid_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [8:0] rgb;
        logic       hs, vs, hb, vb;
        logic [7:0] r, g, b;
        logic       ohs, ovs, de;
    } vec_t;

    typedef struct {
        logic [7:0] r, g, b;
        logic       hs, vs, de;
    } exp_t;

    vec_t vecs[NVEC];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Replicate eight times and keep the top byte.
    function automatic logic [7:0] model_expand(input logic [2:0] c);
        logic [23:0] rep;
        rep = {c, c, c, c, c, c, c, c};
        return rep[23:16];
    endfunction

    function automatic vec_t make_vec(input logic [8:0] rgb, input logic hs, input logic vs,
                                      input logic hb, input logic vb);
        vec_t v;
        v.rgb = rgb; v.hs = hs; v.vs = vs; v.hb = hb; v.vb = vb;
        v.r   = (hb | vb) ? 8'h00 : model_expand(rgb[2:0]);
        v.g   = (hb | vb) ? 8'h00 : model_expand(rgb[5:3]);
        v.b   = (hb | vb) ? 8'h00 : model_expand(rgb[8:6]);
        v.ohs = ~hs;
        v.ovs = ~vs;
        v.de  = ~(hb | vb);
        return v;
    endfunction

    task automatic strobe();
        ce_pix = 1'b1;
        @(posedge clk_sys);
        #1;
        ce_pix = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        hsync_i = 1'b0; vsync_i = 1'b0; hblank_i = 1'b0; vblank_i = 1'b0; rgb_i = '0;
        #2;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        idle();
    endtask

    task automatic compare_pop();
        exp_t e;
        e = sb.pop_front();
        check("pipe_r",  32'(VGA_R),  32'(e.r));
        check("pipe_g",  32'(VGA_G),  32'(e.g));
        check("pipe_b",  32'(VGA_B),  32'(e.b));
        check("pipe_hs", 32'(VGA_HS), 32'(e.hs));
        check("pipe_vs", 32'(VGA_VS), 32'(e.vs));
        check("pipe_de", 32'(VGA_DE), 32'(e.de));
    endtask

    task automatic apply_vec(input vec_t v);
        exp_t e;
        rgb_i = v.rgb; hsync_i = v.hs; vsync_i = v.vs; hblank_i = v.hb; vblank_i = v.vb;
        e.r = v.r; e.g = v.g; e.b = v.b; e.hs = v.ohs; e.vs = v.ovs; e.de = v.de;
        sb.push_back(e);
        strobe();
        if (sb.size() >= 2) compare_pop();
    endtask

    task automatic drive_px(input int x, input int l);
        hsync_i  = (x < 8);
        vsync_i  = (l == 0);
        hblank_i = (x >= 80);
        vblank_i = (l >= V_TOT - 2);
        rgb_i    = 9'($urandom);
    endtask

    task automatic run_lines(input int first, input int last);
        for (int l = first; l <= last; l++) begin
            for (int x = 0; x < H_TOT; x++) begin
                drive_px(x, l);
                strobe();
                idle();
            end
        end
    endtask

    // One frame: the first pixel carries the vs edge that closes the previous frame.
    task automatic frame(input int nlines, input int exp_lines, input logic exp_valid,
                         input int exp_fcnt);
        drive_px(0, 0);
        strobe();
        check("fs_pulse",    32'(frame_start_o), 32'd1);
        check("frame_lines", 32'(frame_lines_o), 32'(exp_lines));
        check("line_len",    32'(line_len_o),    32'(H_TOT));
        check("v_cnt_edge",  32'(v_cnt_o),       32'd0);
        check("frame_cnt",   32'(frame_cnt_o),   32'(exp_fcnt));
        check("geom_valid",  32'(geom_valid_o),  32'(exp_valid));
        idle();
        check("fs_one_cyc",  32'(frame_start_o), 32'd0);
        for (int x = 1; x < H_TOT; x++) begin
            drive_px(x, 0);
            strobe();
            idle();
        end
        if (nlines > 1) run_lines(1, nlines - 1);
    endtask

    initial begin
        vecs[0] = '{9'b001_010_101, 0, 0, 0, 0, 8'hB6, 8'h49, 8'h24, 1, 1, 1};
        vecs[1] = '{9'b001_010_101, 0, 0, 0, 0, 8'hB6, 8'h49, 8'h24, 1, 1, 1};
        vecs[2] = '{9'b001_010_101, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0};
        vecs[3] = '{9'b001_010_101, 1, 0, 0, 0, 8'hB6, 8'h49, 8'h24, 0, 1, 1};
        vecs[4] = '{9'b111_000_011, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0};
        vecs[5] = '{9'b111_000_011, 0, 0, 0, 0, 8'h6D, 8'h00, 8'hFF, 1, 1, 1};
        vecs[6] = '{9'b100_110_000, 1, 1, 0, 0, 8'h00, 8'hDB, 8'h92, 0, 0, 1};
        for (int i = 7; i < NVEC; i++) begin
            vecs[i] = make_vec(9'($urandom), 1'($urandom), 1'($urandom),
                               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        // Reset values
        #12;
        check("rst_r",      32'(VGA_R),         32'd0);
        check("rst_hs",     32'(VGA_HS),        32'd1);
        check("rst_vs",     32'(VGA_VS),        32'd1);
        check("rst_de",     32'(VGA_DE),        32'd0);
        check("rst_h_cnt",  32'(h_cnt_o),       32'd0);
        check("rst_fcnt",   32'(frame_cnt_o),   32'd0);
        check("rst_fs",     32'(frame_start_o), 32'd0);
        check("rst_valid",  32'(geom_valid_o),  32'd0);
        reset_n = 1'b1;
        idle();

        // Colour pipeline: table through the scoreboard, then flush
        for (int i = 0; i < NVEC; i++) apply_vec(vecs[i]);
        for (int i = 0; i < 2; i++) apply_vec(make_vec(9'h000, 0, 0, 1, 1));

        // ce_pix low holds outputs
        rgb_i = 9'h1FF; hblank_i = 1'b0; vblank_i = 1'b0;
        idle();
        idle();
        check("ce_hold_de", 32'(VGA_DE), 32'd0);

        // h_cnt saturation with no hsync
        do_reset();
        for (int i = 0; i < 1100; i++) strobe();
        check("h_sat",       32'(h_cnt_o),    32'd1023);
        check("h_sat_len0",  32'(line_len_o), 32'd0);
        hsync_i = 1'b1;
        strobe();
        check("h_sat_len",   32'(line_len_o), 32'd1023);
        check("h_sat_clr",   32'(h_cnt_o),    32'd0);
        check("h_sat_vinc",  32'(v_cnt_o),    32'd1);

        // Coincident hs and vs edges
        do_reset();
        for (int i = 0; i < 3; i++) begin
            hsync_i = 1'b1; strobe();
            hsync_i = 1'b0; strobe();
        end
        check("pre_v_cnt", 32'(v_cnt_o), 32'd3);
        hsync_i = 1'b1; vsync_i = 1'b1;
        strobe();
        check("both_v_cnt",  32'(v_cnt_o),       32'd0);
        check("both_lines",  32'(frame_lines_o), 32'd4);
        check("both_len",    32'(line_len_o),    32'd2);
        check("both_fcnt",   32'(frame_cnt_o),   32'd1);
        check("both_fs",     32'(frame_start_o), 32'd1);

        // Raster lock, short-frame unlock, relock
        do_reset();
        run_lines(1, V_TOT - 1);
        frame(V_TOT,     V_TOT,     1'b0, 1);
        frame(V_TOT,     V_TOT,     1'b1, 2);
        frame(V_TOT - 1, V_TOT,     1'b1, 3);
        frame(V_TOT,     V_TOT - 1, 1'b0, 4);
        frame(V_TOT,     V_TOT,     1'b0, 5);
        frame(1,         V_TOT,     1'b1, 6);

        // Asynchronous reset mid-line, then release with vs already asserted
        rgb_i = 9'h1FF; hsync_i = 1'b0; vsync_i = 1'b0; hblank_i = 1'b0; vblank_i = 1'b0;
        strobe();
        strobe();
        check("pre_rst_r",  32'(VGA_R),  32'hFF);
        check("pre_rst_de", 32'(VGA_DE), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_r",      32'(VGA_R),         32'd0);
        check("arst_g",      32'(VGA_G),         32'd0);
        check("arst_b",      32'(VGA_B),         32'd0);
        check("arst_hs",     32'(VGA_HS),        32'd1);
        check("arst_vs",     32'(VGA_VS),        32'd1);
        check("arst_de",     32'(VGA_DE),        32'd0);
        check("arst_h_cnt",  32'(h_cnt_o),       32'd0);
        check("arst_v_cnt",  32'(v_cnt_o),       32'd0);
        check("arst_len",    32'(line_len_o),    32'd0);
        check("arst_lines",  32'(frame_lines_o), 32'd0);
        check("arst_fcnt",   32'(frame_cnt_o),   32'd0);
        check("arst_valid",  32'(geom_valid_o),  32'd0);
        vsync_i = 1'b1;
        #1;
        reset_n = 1'b1;
        strobe();
        check("rel_fs",   32'(frame_start_o), 32'd1);
        check("rel_fcnt", 32'(frame_cnt_o),   32'd1);
        idle();
        check("rel_fs_off", 32'(frame_start_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sim_video_out.md
# sim_video_out

Parametrised video output stage for the Verilator simulation tops. Sits between an arcade core's packed RGB/sync outputs and the harness's VGA_* ports. Per channel it:
- expands N-bit colour to OUT_W bits by MSB-first bit replication;
- normalises sync polarity and forces blanking to black;
- measures raster geometry so the harness can size and lock its framebuffer without per-core constants.

## Interface
Parameters:
- IN_W, 3, bits per colour channel from the core (1..OUT_W; IN_W > OUT_W is an elaboration error)
- OUT_W, 8, bits per output channel
- BGR, 1, 1: rgb_i packs {B,G,R} (blue in MSBs); 0: packs {R,G,B}
- HS_IN_LOW, 0, 1: hsync_i is active-low
- VS_IN_LOW, 0, 1: vsync_i is active-low
- CNT_W, 10, width of the horizontal and vertical counters
- FRM_W, 16, width of the frame counter

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce_pix  in  1  pixel clock enable; the pipeline and counters advance only when this is high
- rgb_i  in  3*IN_W  packed core colour
- hsync_i, vsync_i  in  1  core syncs, polarity set by HS_IN_LOW / VS_IN_LOW
- hblank_i, vblank_i  in  1  active-high blanking
- VGA_R, VGA_G, VGA_B  out  OUT_W  expanded colour, zero while blanked
- VGA_HS, VGA_VS  out  1  active-low syncs
- VGA_DE  out  1  data enable, equal to ~(hblank|vblank) after the pipeline
- h_cnt_o, v_cnt_o  out  CNT_W  current pixel and line position
- line_len_o  out  CNT_W  last measured pixels per line
- frame_lines_o  out  CNT_W  last measured lines per frame
- frame_cnt_o  out  FRM_W  completed frames, wraps
- frame_start_o  out  1  one clk_sys pulse per vsync assertion edge
- geom_valid_o  out  1  geometry locked

## Operation
- Sync normalisation: hs = hsync_i ^ HS_IN_LOW; vs = vsync_i ^ VS_IN_LOW, so both are active-high internally.
- Expansion of input channel c[IN_W-1:0]: replicate c ceil(OUT_W/IN_W) times, concatenated MSB-first, and keep the top OUT_W bits.
  - IN_W=3, OUT_W=8 gives {c,c,c[2:1]}; 3'b101 → 8'hB6.
  - IN_W == OUT_W is a pass-through.
- Blank gating: if hblank or vblank is high in stage 1, stage 2 colour is 0.
- Edge detection: registered copies of hs and vs, updated on ce_pix. An "edge" is a 0→1 transition of the normalised signal, seen on a ce_pix cycle.
- Horizontal counter:
  - h_cnt increments on each ce_pix and saturates at all-ones (it does not wrap).
  - On an hs edge, line_len_o ← h_cnt+1 (saturating), h_cnt ← 0, and v_cnt increments (saturating).
- Vertical counter: on a vs edge, frame_lines_o ← v_cnt+1, v_cnt ← 0, frame_cnt increments (wraps), and frame_start_o pulses.
- Simultaneous hs and vs edges: apply both. v_cnt ← 0, and the hs increment is discarded.
- Geometry FSM, evaluated on each vs edge:
  - UNLOCK → CHECK on the first vs edge; capture line_len and frame_lines as the reference.
  - CHECK → LOCKED if both new measurements equal the reference; otherwise recapture and stay in CHECK.
  - LOCKED → CHECK on any mismatch, and recapture.
  - geom_valid_o = (state == LOCKED).
  - A saturated measurement (all-ones) always counts as a mismatch.

## Timing
- Pipeline: two stages, both enabled by ce_pix. Inputs are registered in stage 1; expansion and gating happen in stage 2.
- Colour, syncs and VGA_DE appear on the outputs 2 ce_pix strobes after input. Syncs and DE are delayed identically to colour, so there is zero skew.
- Counter and measurement outputs are registered and update in the clk_sys cycle of the ce_pix that carried the edge.
- frame_start_o is high for exactly that one clk_sys cycle.
- ce_pix low: all state holds and frame_start_o is 0.
- Reset values (asynchronous, on reset_n low; the block restarts cleanly on reset mid-frame):
  - colour 0, VGA_HS=1, VGA_VS=1, VGA_DE=0;
  - all counters and measurements 0, frame_start_o=0, FSM in UNLOCK, geom_valid_o=0;
  - edge-detect registers hold the normalised-inactive value, so a sync that is already asserted at release counts as an edge on the first ce_pix.

## Structure
- Package sim_video_pkg holds:
  - geom_state_t (UNLOCK, CHECK, LOCKED);
  - a function expand(c, IN_W, OUT_W);
  - localparams for the default 3→8 mapping.
- One sub-module, sim_raster_meter. It holds the edge detectors, counters and geometry FSM, and is reusable by other sim tops.
- The colour pipeline stays in the top.

## Test plan
- IN_W=3, OUT_W=8, BGR=1; rgb_i=9'b001_010_101 with blanking off, held for 2 ce_pix → VGA_R=8'hB6, VGA_G=8'h49, VGA_B=8'h24, VGA_DE=1.
- Same colour with hblank=1 → 2 strobes later VGA_R/G/B=0 and VGA_DE=0. VGA_HS/VGA_VS track the inputs with a 2-strobe delay, inverted relative to the active-high input.
- Raster of 384 pixels/line and 264 lines/frame, ce_pix every other clock:
  - after the first vs edge, line_len_o=384 and frame_lines_o=264;
  - geom_valid_o=1 after the second vs edge;
  - frame_cnt_o increments once per frame with a one-cycle frame_start_o.
- After lock, shorten one frame to 263 lines → geom_valid_o drops at that vs edge and returns to 1 after the next matching frame.
- hs and vs edges on the same ce_pix → v_cnt_o=0 and frame_lines_o is set. No hsync for 1100 ce_pix with CNT_W=10 → h_cnt_o holds at 1023.
- Assert reset_n=0 mid-line → all outputs take their reset values immediately without a clock. After release with vs already high, the first ce_pix produces frame_start_o.
